// File: rtl/vram_arbiter_if.sv
// CPU-side request/acknowledge bus into the framebuffer arbiter.
// The CPU holds a request stable until it sees a single-clock acknowledge.
interface vram_arbiter_if #(
    parameter int ADDR_W = 15
) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;

    modport master (
        output cpu_req,
        output cpu_we,
        output cpu_addr,
        output cpu_wdata,
        input  cpu_ack,
        input  cpu_rdata
    );

    modport slave (
        input  cpu_req,
        input  cpu_we,
        input  cpu_addr,
        input  cpu_wdata,
        output cpu_ack,
        output cpu_rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares the single-port RGB332 framebuffer RAM between VGA scan-out (absolute
// priority) and the CPU bus, and drives the registered pixel colour.
module vram_arbiter #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              pix_ce,
    input  logic              vis_en,
    input  logic [9:0]        vis_x,
    input  logic [9:0]        vis_y,

    vram_arbiter_if.slave     cpu,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,

    output logic [7:0]        pix_rgb,
    output logic              scan_overrun
);

    localparam logic [ADDR_W:0] FB_SIZE = (ADDR_W+1)'(FB_W * FB_H);

    typedef enum logic {
        C_IDLE,
        C_ACK
    } cpu_state_t;

    cpu_state_t        cpu_state;
    logic              cpu_ack_q;
    logic              cpu_rd_live;

    logic              scan_pend;
    logic [ADDR_W-1:0] scan_addr;
    logic              rd_is_scan;

    logic              scan_req;
    logic [9:0]        xq;
    logic [9:0]        yq;
    logic [ADDR_W-1:0] scan_addr_next;
    logic              cpu_in_range;
    logic              cpu_take;
    logic              cpu_ram;

    // Only the first screen pixel of each 4-wide fb pixel fetches; y*160 as shifts.
    assign scan_req       = pix_ce && vis_en && (vis_x[1:0] == 2'b00);
    assign xq             = vis_x >> 2;
    assign yq             = vis_y >> 2;
    assign scan_addr_next = (ADDR_W'(yq) << 7) + (ADDR_W'(yq) << 5) + ADDR_W'(xq);

    assign cpu_in_range = ({1'b0, cpu.cpu_addr} < FB_SIZE);

    // CPU is accepted only in a free slot; out-of-range accesses still take the
    // ack path but never touch the RAM. rst_n gating keeps the RAM quiet in reset.
    assign cpu_take = rst_n && cpu.cpu_req && (cpu_state == C_IDLE)
                      && !cpu_ack_q && !scan_pend;
    assign cpu_ram  = cpu_take && cpu_in_range;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = 8'h00;
        if (scan_pend) begin
            ram_en   = 1'b1;
            ram_addr = scan_addr;
        end else if (cpu_ram) begin
            ram_en    = 1'b1;
            ram_we    = cpu.cpu_we;
            ram_addr  = cpu.cpu_addr;
            ram_wdata = cpu.cpu_we ? cpu.cpu_wdata : 8'h00;
        end
    end

    // A scan request is always issued the clock after it is registered, so a
    // request landing while one is still pending means pix_ce misbehaved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_pend    <= 1'b0;
            scan_addr    <= '0;
            scan_overrun <= 1'b0;
        end else if (scan_req) begin
            scan_pend <= 1'b1;
            scan_addr <= scan_addr_next;
            if (scan_pend) begin
                scan_overrun <= 1'b1;
            end
        end else begin
            scan_pend <= 1'b0;
        end
    end

    // Return tag: the RAM answers one clock after issue, so remember who asked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_is_scan <= 1'b0;
            pix_rgb    <= 8'h00;
        end else begin
            rd_is_scan <= scan_pend;
            if (pix_ce && !vis_en) begin
                pix_rgb <= 8'h00;
            end else if (rd_is_scan) begin
                pix_rgb <= ram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_state   <= C_IDLE;
            cpu_ack_q   <= 1'b0;
            cpu_rd_live <= 1'b0;
        end else begin
            case (cpu_state)
                C_IDLE: begin
                    cpu_ack_q   <= 1'b0;
                    cpu_rd_live <= 1'b0;
                    if (cpu_take) begin
                        cpu_state   <= C_ACK;
                        cpu_ack_q   <= 1'b1;
                        cpu_rd_live <= !cpu.cpu_we && cpu_in_range;
                    end
                end
                C_ACK: begin
                    cpu_state   <= C_IDLE;
                    cpu_ack_q   <= 1'b0;
                    cpu_rd_live <= 1'b0;
                end
                default: begin
                    cpu_state   <= C_IDLE;
                    cpu_ack_q   <= 1'b0;
                    cpu_rd_live <= 1'b0;
                end
            endcase
        end
    end

    // Read data lands in the ack cycle, so it is steered straight from the RAM.
    assign cpu.cpu_ack   = cpu_ack_q;
    assign cpu.cpu_rdata = cpu_rd_live ? ram_rdata : 8'h00;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural RAM, CPU read scoreboard and directed
// scan-out, collision, overrun and reset sequences.
module tb_vram_arbiter;

    localparam int ADDR_W  = 15;
    localparam int FB_SIZE = 19200;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pix_ce = 1'b0;
    logic              vis_en = 1'b0;
    logic [9:0]        vis_x = '0;
    logic [9:0]        vis_y = '0;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic [7:0]        pix_rgb;
    logic              scan_overrun;

    vram_arbiter_if #(.ADDR_W(ADDR_W)) cpu_bus ();

    vram_arbiter #(
        .FB_W  (160),
        .FB_H  (120),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_ce      (pix_ce),
        .vis_en      (vis_en),
        .vis_x       (vis_x),
        .vis_y       (vis_y),
        .cpu         (cpu_bus),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .pix_rgb     (pix_rgb),
        .scan_overrun(scan_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_read;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ram_mem [0:32767];
    logic [7:0] ref_mem [0:FB_SIZE-1];
    int         checks = 0;
    int         errors = 0;
    int         ram_access_cnt = 0;
    int         ack_cnt = 0;

    // Synchronous single-port RAM, data valid the clock after a read issue.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Every cpu_ack consumes one scoreboard entry; read entries carry the data.
    always @(negedge clk) begin
        exp_t e;
        if (ram_en) ram_access_cnt++;
        if (cpu_bus.cpu_ack) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_ack", cpu_bus.cpu_ack, 0);
            end else begin
                e = exp_q.pop_front();
                if (e.is_read) checkOutput("cpu_rdata", cpu_bus.cpu_rdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pixelStrobe(input logic en, input int x, input int y);
        pix_ce = 1'b1;
        vis_en = en;
        vis_x  = 10'(x);
        vis_y  = 10'(y);
        tick();
        pix_ce = 1'b0;
        vis_en = 1'b0;
    endtask

    task automatic expectAccess(input logic we, input int addr, input logic [7:0] wdata);
        exp_t e;
        e.is_read = !we;
        e.data    = 8'h00;
        if (!we && addr < FB_SIZE) e.data = ref_mem[addr];
        if (we && addr < FB_SIZE) ref_mem[addr] = wdata;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic we, input int addr, input logic [7:0] wdata);
        bit got = 0;
        expectAccess(we, addr, wdata);
        cpu_bus.cpu_we    = we;
        cpu_bus.cpu_addr  = ADDR_W'(addr);
        cpu_bus.cpu_wdata = wdata;
        cpu_bus.cpu_req   = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (cpu_bus.cpu_ack) begin
                got = 1;
                break;
            end
        end
        cpu_bus.cpu_req = 1'b0;
        if (!got) checkOutput("ack_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a0;
        int k0;
        for (int i = 0; i < 32768; i++) ram_mem[i] = 8'h00;
        for (int i = 0; i < FB_SIZE; i++) ref_mem[i] = 8'h00;
        ram_mem[19199] = 8'hE0; ref_mem[19199] = 8'hE0;
        ram_mem[161]   = 8'h5A; ref_mem[161]   = 8'h5A;
        ram_mem[20000] = 8'h77;

        // A pending CPU request during reset must not reach the RAM.
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = 1'b0;
        cpu_bus.cpu_addr  = ADDR_W'(5);
        cpu_bus.cpu_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ram_en", ram_en, 0);
        checkOutput("reset_ram_addr", ram_addr, 0);
        checkOutput("reset_cpu_ack", cpu_bus.cpu_ack, 0);
        checkOutput("reset_pix_rgb", pix_rgb, 0);
        checkOutput("reset_overrun", scan_overrun, 0);
        cpu_bus.cpu_req = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();

        pixelStrobe(1'b1, 636, 476);
        @(negedge clk);
        checkOutput("scan_ram_en", ram_en, 1);
        checkOutput("scan_ram_we", ram_we, 0);
        checkOutput("scan_ram_addr", ram_addr, 19199);
        @(negedge clk);
        checkOutput("scan_pix_early", pix_rgb, 8'h00);
        @(negedge clk);
        checkOutput("scan_pix_rgb", pix_rgb, 8'hE0);
        for (int x = 637; x <= 639; x++) begin
            repeat (3) tick();
            pixelStrobe(1'b1, x, 476);
            @(negedge clk);
            checkOutput("scan_no_refetch", ram_en, 0);
            checkOutput("scan_pix_hold", pix_rgb, 8'hE0);
        end

        tick();
        a0 = ram_access_cnt;
        pixelStrobe(1'b0, 0, 0);
        @(negedge clk);
        checkOutput("blank_pix_rgb", pix_rgb, 8'h00);
        repeat (3) tick();
        checkOutput("blank_ram_access", ram_access_cnt - a0, 0);

        tick();
        pixelStrobe(1'b1, 8, 8);
        fork
            applyStimulus(1'b1, 100, 8'h1C);
            begin
                @(negedge clk);
                checkOutput("coll_scan_en", ram_en, 1);
                checkOutput("coll_scan_we", ram_we, 0);
                checkOutput("coll_scan_addr", ram_addr, 322);
                @(negedge clk);
                checkOutput("coll_cpu_en", ram_en, 1);
                checkOutput("coll_cpu_we", ram_we, 1);
                checkOutput("coll_cpu_addr", ram_addr, 100);
                checkOutput("coll_cpu_wdata", ram_wdata, 8'h1C);
                @(negedge clk);
                checkOutput("coll_ack", cpu_bus.cpu_ack, 1);
            end
        join
        tick();
        applyStimulus(1'b0, 100, 8'h00);

        // Request held high across five clocks: one access per two-clock window.
        tick();
        a0 = ram_access_cnt;
        k0 = ack_cnt;
        for (int i = 0; i < 3; i++) expectAccess(1'b0, 100, 8'h00);
        cpu_bus.cpu_we   = 1'b0;
        cpu_bus.cpu_addr = ADDR_W'(100);
        cpu_bus.cpu_req  = 1'b1;
        repeat (5) tick();
        cpu_bus.cpu_req = 1'b0;
        repeat (3) tick();
        checkOutput("held_ram_access", ram_access_cnt - a0, 3);
        checkOutput("held_acks", ack_cnt - k0, 3);

        a0 = ram_access_cnt;
        k0 = ack_cnt;
        applyStimulus(1'b0, 20000, 8'h00);
        tick();
        applyStimulus(1'b1, 20000, 8'hAA);
        tick();
        checkOutput("oor_ram_access", ram_access_cnt - a0, 0);
        checkOutput("oor_acks", ack_cnt - k0, 2);
        checkOutput("oor_ram_unchanged", ram_mem[20000], 8'h77);

        tick();
        checkOutput("overrun_pre", scan_overrun, 0);
        pix_ce = 1'b1;
        vis_en = 1'b1;
        vis_x  = 10'd0;
        vis_y  = 10'd4;
        tick();
        vis_x  = 10'd4;
        tick();
        pix_ce = 1'b0;
        vis_en = 1'b0;
        @(negedge clk);
        checkOutput("overrun_set", scan_overrun, 1);
        repeat (5) tick();
        checkOutput("overrun_held", scan_overrun, 1);
        checkOutput("overrun_pix_rgb", pix_rgb, 8'h5A);

        // Reset lands in the middle of an issued CPU read.
        tick();
        k0 = ack_cnt;
        cpu_bus.cpu_we   = 1'b0;
        cpu_bus.cpu_addr = ADDR_W'(100);
        cpu_bus.cpu_req  = 1'b1;
        #2;
        checkOutput("midrst_pre_ram_en", ram_en, 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_cpu_ack", cpu_bus.cpu_ack, 0);
        checkOutput("midrst_cpu_rdata", cpu_bus.cpu_rdata, 0);
        checkOutput("midrst_ram_en", ram_en, 0);
        checkOutput("midrst_ram_we", ram_we, 0);
        checkOutput("midrst_ram_addr", ram_addr, 0);
        checkOutput("midrst_ram_wdata", ram_wdata, 0);
        checkOutput("midrst_pix_rgb", pix_rgb, 0);
        checkOutput("midrst_overrun", scan_overrun, 0);
        repeat (2) tick();
        cpu_bus.cpu_req = 1'b0;
        rst_n = 1'b1;
        repeat (4) tick();
        checkOutput("midrst_no_ack", ack_cnt - k0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
